// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: type codes, field layout and the flit assembler used by NI TX and RX.
// NI_TX_PARITY_EN selects even parity in bit 0 (7-bit packet id, 27-bit payload).
package noc_flit_pkg;

  localparam int NOC_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    FLIT_HDR  = 3'b001,
    FLIT_BODY = 3'b010,
    FLIT_TAIL = 3'b100
  } flit_type_e;

  // Field offsets are absolute flit bit positions; FIELD_* spans everything below the type.
  localparam int TYPE_LSB  = 29;
  localparam int TYPE_W    = 3;
  localparam int FIELD_LSB = 1;
  localparam int FIELD_W   = 28;
  localparam int LEN_LSB   = 17;
  localparam int LEN_W     = 12;
  localparam int DST_LSB   = 13;
  localparam int DST_W     = 4;
  localparam int SRC_LSB   = 9;
  localparam int SRC_W     = 4;
  localparam int ID_LSB    = 1;
  localparam int ID_W      = 8;

`ifdef NI_TX_PARITY_EN
  localparam logic              PAR_EN  = 1'b1;
  localparam logic [ID_W-1:0]   ID_MASK = 8'h7F;
  localparam logic [FIELD_W-1:0] PL_MASK = 28'hFFF_FFFE;
`else
  localparam logic              PAR_EN  = 1'b0;
  localparam logic [ID_W-1:0]   ID_MASK = 8'hFF;
  localparam logic [FIELD_W-1:0] PL_MASK = 28'hFFF_FFFF;
`endif

  // Without parity, bit 0 mirrors the field LSB so the flit stays fully defined.
  function automatic logic [NOC_DATA_WIDTH-1:0] flit_assemble(
    input flit_type_e         ftype,
    input logic [FIELD_W-1:0] field,
    input logic               parity_en
  );
    logic [NOC_DATA_WIDTH-1:0] f;
    f = '0;
    f[TYPE_LSB +: TYPE_W]   = ftype;
    f[FIELD_LSB +: FIELD_W] = field;
    f[0]                    = parity_en ? ^f[NOC_DATA_WIDTH-1:1] : field[0];
    return f;
  endfunction

endpackage

// File: rtl/ni_flit_fmt.sv
// Combinational header/body/tail flit assembly for the NI transmitter.
// NI_TX_PARITY_EN (via noc_flit_pkg) masks pkt_id to 7 bits, drops pl_data[0] and adds parity.
module ni_flit_fmt
  import noc_flit_pkg::*;
#(
  parameter logic [3:0] SRC_ADDR = 4'd3
) (
  input  logic [LEN_W-1:0]          pkt_len,
  input  logic [DST_W-1:0]          dst,
  input  logic [ID_W-1:0]           pkt_id,
  input  logic [FIELD_W-1:0]        pl_data,
  output logic [NOC_DATA_WIDTH-1:0] hdr_flit,
  output logic [NOC_DATA_WIDTH-1:0] body_flit,
  output logic [NOC_DATA_WIDTH-1:0] tail_flit
);

  logic [FIELD_W-1:0] hdr_field;
  logic [FIELD_W-1:0] pl_field;

  always_comb begin
    hdr_field = '0;
    hdr_field[LEN_LSB-FIELD_LSB +: LEN_W] = pkt_len;
    hdr_field[DST_LSB-FIELD_LSB +: DST_W] = dst;
    hdr_field[SRC_LSB-FIELD_LSB +: SRC_W] = SRC_ADDR;
    hdr_field[ID_LSB-FIELD_LSB +: ID_W]   = pkt_id & ID_MASK;
    pl_field = pl_data & PL_MASK;
  end

  assign hdr_flit  = flit_assemble(FLIT_HDR,  hdr_field, PAR_EN);
  assign body_flit = flit_assemble(FLIT_BODY, pl_field,  PAR_EN);
  assign tail_flit = flit_assemble(FLIT_TAIL, pl_field,  PAR_EN);

endmodule

// File: rtl/ni_packet_tx.sv
// NI transmitter: turns PE packet requests into header/body/tail flits for a router input port.
// Build option NI_TX_PARITY_EN adds even parity in flit bit 0 and narrows pkt_id to 7 bits.
module ni_packet_tx
  import noc_flit_pkg::*;
#(
  parameter int         DATA_WIDTH  = 32,
  parameter int         MAX_PAYLOAD = 64,
  parameter logic [3:0] SRC_ADDR    = 4'd3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_dst,
  input  logic [11:0]           req_len,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  input  logic [27:0]           pl_data,
  output logic [DATA_WIDTH-1:0] TX,
  output logic                  RTS,
  input  logic                  DCTS,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  req_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_TAIL
  } state_e;

  localparam logic [11:0] MAX_LEN = 12'(MAX_PAYLOAD);

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [3:0]            dst_q, dst_d;
  logic [11:0]           len_q, len_d;
  logic [11:0]           rem_q, rem_d;
  logic [7:0]            pkt_id_q, pkt_id_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  rts_q, rts_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  len_ok;
  logic [11:0]           hdr_len;
  logic [31:0]           hdr_flit, body_flit, tail_flit;

  ni_flit_fmt #(
    .SRC_ADDR (SRC_ADDR)
  ) u_fmt (
    .pkt_len   (hdr_len),
    .dst       (dst_q),
    .pkt_id    (pkt_id_q),
    .pl_data   (pl_data),
    .hdr_flit  (hdr_flit),
    .body_flit (body_flit),
    .tail_flit (tail_flit)
  );

  // Header length field counts the header itself.
  assign hdr_len   = len_q + 12'd1;
  assign len_ok    = (req_len != 12'd0) && (req_len <= MAX_LEN);
  assign req_ready = armed_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign TX        = tx_q;
  assign RTS       = rts_q;
  assign pkt_done  = done_q;
  assign req_err   = err_q;

  always_comb begin
    state_d  = state_q;
    armed_d  = 1'b1;
    dst_d    = dst_q;
    len_d    = len_q;
    rem_d    = rem_q;
    pkt_id_d = pkt_id_q;
    tx_d     = tx_q;
    rts_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pl_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (len_ok) begin
            state_d = S_HDR;
            dst_d   = req_dst;
            len_d   = req_len;
            rem_d   = req_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_HDR: begin
        if (DCTS) begin
          tx_d    = hdr_flit;
          rts_d   = 1'b1;
          state_d = (len_q == 12'd1) ? S_TAIL : S_BODY;
        end
      end

      S_BODY: begin
        if (DCTS && pl_valid) begin
          pl_ready = 1'b1;
          tx_d     = body_flit;
          rts_d    = 1'b1;
          if (rem_q != 12'd0) begin
            rem_d = rem_q - 12'd1;
          end
          if (rem_q <= 12'd2) begin
            state_d = S_TAIL;
          end
        end
      end

      S_TAIL: begin
        if (DCTS && pl_valid) begin
          pl_ready = 1'b1;
          tx_d     = tail_flit;
          rts_d    = 1'b1;
          done_d   = 1'b1;
          if (rem_q != 12'd0) begin
            rem_d = rem_q - 12'd1;
          end
          pkt_id_d = (pkt_id_q + 8'd1) & ID_MASK;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      dst_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      pkt_id_q <= '0;
      tx_q     <= '0;
      rts_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      pkt_id_q <= pkt_id_d;
      tx_q     <= tx_d;
      rts_q    <= rts_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule
